// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage port bundle: imem request/response, redirect, decode handoff
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, in-order imem requests, word FIFO to decode
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];

  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic          live;
  logic [CW-1:0] out_next;
  logic [CW:0]   occupancy;

  always_comb begin
    occupancy       = {1'b0, outstanding} + {1'b0, count};
    bus.imem_req    = ~rst & (occupancy < (CW+1)'(DEPTH));
    bus.imem_addr   = pc;
    grant           = bus.imem_req & bus.imem_gnt;
    resp            = bus.imem_rvalid & (outstanding != '0);
    push            = resp & (kill == '0) & ~bus.redirect;
    live            = (count != '0);
    pop             = live & bus.id_ready;
    out_next        = outstanding + CW'(grant) - CW'(resp);
    bus.inst_valid  = live;
    bus.instruction = live ? word_mem[rd_ptr] : NOP_WORD;
    bus.inst_pc     = live ? pc_mem[rd_ptr] : 32'h0;
  end

  // Responses come back in grant order, so the next live word's PC is just a
  // running counter re-seeded on redirect; killed words never advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (bus.redirect) begin
        pc     <= {bus.redirect_pc[31:2], 2'b00};
        rsp_pc <= {bus.redirect_pc[31:2], 2'b00};
        kill   <= out_next;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (resp && kill != '0) kill <= kill - 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      word_mem[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule
